// File: rtl/cnt_fnd_disp_if.sv
// ---------------------------------------------------------------------------
// cnt_fnd_disp_if
// Bundle between the seconds counter and the display stage.
//   in   [5:0] : binary count from the counter (0..63)
//   bcd  [7:0] : converted value {tens, ones}
//   busy       : conversion in progress
//   seg  [6:0] : segments {g,f,e,d,c,b,a}, active-low
//   com  [1:0] : digit enables, active-low; com[0] = ones, com[1] = tens
// master = counter side (drives in), slave = display stage.
// ---------------------------------------------------------------------------
interface cnt_fnd_disp_if;
    logic [5:0] in;
    logic [7:0] bcd;
    logic       busy;
    logic [6:0] seg;
    logic [1:0] com;

    modport master (output in, input bcd, busy, seg, com);
    modport slave  (input in, output bcd, busy, seg, com);
endinterface

// File: rtl/cnt_fnd_disp.sv
// ---------------------------------------------------------------------------
// cnt_fnd_disp
// Converts the 6-bit seconds count to two BCD digits with a sequential
// shift-add-3 engine and multiplexes them onto a 2-digit common-anode
// seven-segment display.
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active-high (1 = reset)
//   bus   : cnt_fnd_disp_if.slave (in, bcd, busy, seg, com)
// Parameters:
//   SCAN_DIV : clock cycles per digit slot (2 .. 2**20)
//   BLANK_LZ : 1 = blank the tens digit when it is zero
// ---------------------------------------------------------------------------
module cnt_fnd_disp #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    cnt_fnd_disp_if.slave  bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Converter state
    state_t     r_state;
    logic [5:0] r_last;
    logic [5:0] r_shift;
    logic [7:0] r_scratch;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_bcd;

    state_t     w_next_state;
    logic [5:0] w_next_last;
    logic [5:0] w_next_shift;
    logic [7:0] w_next_scratch;
    logic [2:0] w_next_bit_cnt;
    logic [7:0] w_next_bcd;
    logic [7:0] w_adj;

    // Scan state
    logic [CNT_W-1:0] r_scan_cnt;
    logic             r_sel;
    logic [6:0]       r_seg;
    logic [1:0]       r_com;

    logic [3:0] w_digit;
    logic [6:0] w_seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Converter: state register
    // -----------------------------------------------------------------------
    // NOTE: non-blocking (<=) for every register so all flops update from
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= IDLE;
            r_last    <= 6'd0;
            r_shift   <= 6'd0;
            r_scratch <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_bcd     <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_last    <= w_next_last;
            r_shift   <= w_next_shift;
            r_scratch <= w_next_scratch;
            r_bit_cnt <= w_next_bit_cnt;
            r_bcd     <= w_next_bcd;
        end
    end

    // Each BCD nibble >= 5 gets +3 so that the following shift carries
    // correctly into the next decimal digit.
    always_comb begin
        w_adj[3:0] = (r_scratch[3:0] >= 4'd5) ? r_scratch[3:0] + 4'd3 : r_scratch[3:0];
        w_adj[7:4] = (r_scratch[7:4] >= 4'd5) ? r_scratch[7:4] + 4'd3 : r_scratch[7:4];
    end

    // -----------------------------------------------------------------------
    // Converter: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_next_last    = r_last;
        w_next_shift   = r_shift;
        w_next_scratch = r_scratch;
        w_next_bit_cnt = r_bit_cnt;
        w_next_bcd     = r_bcd;

        case (r_state)
            IDLE: begin
                // Changes of in during SHIFT/LOAD are picked up here, so bcd
                // always converges to the final stable input.
                if (bus.in != r_last) begin
                    w_next_last    = bus.in;
                    w_next_shift   = bus.in;
                    w_next_scratch = 8'd0;
                    w_next_bit_cnt = 3'd0;
                    w_next_state   = SHIFT;
                end
            end
            SHIFT: begin
                {w_next_scratch, w_next_shift} = {w_adj, r_shift} << 1;
                w_next_bit_cnt = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd5) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_next_bcd   = r_scratch;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Scan: digit slot timer, select, and registered seg/com pair
    // -----------------------------------------------------------------------
    always_comb begin
        w_digit = r_sel ? r_bcd[7:4] : r_bcd[3:0];
        if (r_sel && BLANK_LZ && (r_bcd[7:4] == 4'd0)) begin
            w_seg_next = 7'b1111111;
        end else begin
            w_seg_next = seg_decode(w_digit);
        end
    end

    // seg and com share one register stage so a digit pattern can never be
    // shown under the other digit's enable.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_scan_cnt <= '0;
            r_sel      <= 1'b0;
            r_seg      <= 7'b1111111;
            r_com      <= 2'b11;
        end else begin
            if (r_scan_cnt == CNT_MAX) begin
                r_scan_cnt <= '0;
                r_sel      <= ~r_sel;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_seg <= w_seg_next;
            r_com <= r_sel ? 2'b01 : 2'b10;
        end
    end

    assign bus.bcd  = r_bcd;
    assign bus.busy = (r_state != IDLE);
    assign bus.seg  = r_seg;
    assign bus.com  = r_com;

endmodule
